// File: rtl/router_pkg.sv
// ============================================================================
// Module      : router_pkg
// Description : Shared types and helpers for the router output-port slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } port_state_t;

  // Flit control fields sit at the top of the flit, whatever its width.
  function automatic int head_bit(input int flit_w);
    return flit_w - 1;
  endfunction

  function automatic int tail_bit(input int flit_w);
    return flit_w - 2;
  endfunction

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/router_rr_arbiter.sv
// ============================================================================
// Module      : router_rr_arbiter
// Description : Combinational round-robin pick of the first request at or
//               after the pointer, searching cyclically.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_rr_arbiter
  import router_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int PTR_W  = clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] i_req,
  input  logic [PTR_W-1:0]  i_ptr,
  output logic [NUM_IN-1:0] o_grant,
  output logic [PTR_W-1:0]  o_grant_idx
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_IN)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_IN);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/router_out_port_ctrl.sv
// ============================================================================
// Module      : router_out_port_ctrl
// Description : Router output port: round-robin wormhole arbitration,
//               credit-gated forwarding and a registered flit output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_out_port_ctrl
  import router_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int FLIT_W  = 32,
  parameter int CREDITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*FLIT_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic                     credit_in,
  output logic                     out_valid,
  output logic [FLIT_W-1:0]        out_data,
  output logic                     credit_err
);

  localparam int c_ptr_w    = clog2(NUM_IN);
  localparam int c_cnt_w    = clog2(CREDITS + 1);
  localparam int c_tail_bit = tail_bit(FLIT_W);
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(CREDITS);

  port_state_t          r_state, w_state_nxt;
  logic [c_ptr_w-1:0]   r_ptr, r_owner, w_sel, w_grant_idx, w_ptr_inc;
  logic [c_cnt_w-1:0]   r_credits;
  logic                 r_credit_err;
  logic [NUM_IN-1:0]    w_grant, w_owner_oh, w_ready;
  logic [FLIT_W-1:0]    w_flit;
  logic                 w_xfer, w_tail, w_cred_ok;

  router_rr_arbiter #(
    .NUM_IN (NUM_IN),
    .PTR_W  (c_ptr_w)
  ) u_arb (
    .i_req       (in_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  generate
    for (genvar i = 0; i < NUM_IN; i++) begin : g_owner_oh
      assign w_owner_oh[i] = (r_owner == c_ptr_w'(i));
    end
  endgenerate

  // Readiness depends only on registered credits, never on credit_in.
  assign w_cred_ok = (r_credits != '0);

  always_comb begin
    w_ready = '0;
    w_sel   = r_owner;
    case (r_state)
      IDLE: begin
        w_sel   = w_grant_idx;
        w_ready = w_cred_ok ? w_grant : '0;
      end
      LOCKED: begin
        w_ready = w_cred_ok ? w_owner_oh : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_flit = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_sel == c_ptr_w'(i)) begin
        w_flit = in_data[i*FLIT_W +: FLIT_W];
      end
    end
  end

  assign w_xfer    = |(in_valid & w_ready);
  assign w_tail    = w_flit[c_tail_bit];
  assign w_ptr_inc = (w_sel == c_ptr_w'(NUM_IN - 1)) ? '0 : w_sel + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_xfer && !w_tail) w_state_nxt = LOCKED;
      LOCKED:  if (w_xfer && w_tail)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr        <= '0;
      r_owner      <= '0;
      r_credits    <= c_full;
      r_credit_err <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
    end else begin
      out_valid <= w_xfer;
      if (w_xfer) out_data <= w_flit;
      if (w_xfer && (r_state == IDLE) && !w_tail) r_owner <= w_grant_idx;
      if (w_xfer && w_tail) r_ptr <= w_ptr_inc;
      // A return and a spend in the same cycle cancel out.
      case ({w_xfer, credit_in})
        2'b10: r_credits <= r_credits - 1'b1;
        2'b01: begin
          if (r_credits == c_full) r_credit_err <= 1'b1;
          else                     r_credits    <= r_credits + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = w_ready;
  assign credit_err = r_credit_err;

endmodule

`default_nettype wire

// File: tb/tb_router_out_port_ctrl.sv
// ============================================================================
// Module      : tb_router_out_port_ctrl
// Description : Directed scoreboard bench for router_out_port_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_router_out_port_ctrl;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           credit_in;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           credit_err;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  router_out_port_ctrl #(.NUM_IN(N), .FLIT_W(W), .CREDITS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .credit_in  (credit_in),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] f(input logic h, input logic t, input logic [29:0] p);
    return {h, t, p};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented flit must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_valid unexpected: got flit %h expected no flit", out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL out_data: got %h expected %h", out_data, e);
        end
      end
    end
  end

  task automatic step(input logic [N-1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                      input logic [W-1:0] d2, input logic [W-1:0] d3,
                      input logic [N-1:0] exp_rdy, input logic cr, input string name);
    logic [W-1:0] d[N];
    d = '{d0, d1, d2, d3};
    in_valid  = v;
    in_data   = {d3, d2, d1, d0};
    credit_in = cr;
    @(negedge clk);
    check(name, {28'b0, in_ready}, {28'b0, exp_rdy});
    for (int i = 0; i < N; i++) begin
      if (exp_rdy[i] && v[i]) exp_q.push_back(d[i]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic cr, input string name);
    step(4'b0000, 0, 0, 0, 0, 4'b0000, cr, name);
  endtask

  task automatic expect_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: got %0d pending flits expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    expect_drained("drain before reset");
    reset     = 1'b1;
    in_valid  = '0;
    credit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] s;
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    credit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset out_valid", {31'b0, out_valid}, 0);
    check("reset out_data", out_data, 0);
    check("reset credit_err", {31'b0, credit_err}, 0);
    idle(0, "reset in_ready");

    // Single-flit packet from requester 2, then pointer should sit at 3.
    step(4'b0100, 0, 0, 32'hFABCDEF0, 0, 4'b0100, 0, "single ready");
    s = f(1, 1, 30'h0000_0011);
    step(4'b1111, s, s + 1, s + 2, s + 3, 4'b1000, 0, "ptr after single");
    idle(1, "credit return a");
    idle(1, "credit return b");

    // Wormhole: requester 0 holds the port while requester 1 waits.
    step(4'b0011, f(1, 0, 30'h100), f(1, 1, 30'h200), 0, 0, 4'b0001, 0, "lock head");
    step(4'b0011, f(0, 0, 30'h101), f(1, 1, 30'h200), 0, 0, 4'b0001, 0, "lock body");
    step(4'b0011, f(1, 1, 30'h102), f(1, 1, 30'h200), 0, 0, 4'b0001, 0, "lock tail");
    step(4'b0010, 0, f(1, 1, 30'h200), 0, 0, 4'b0010, 0, "grant after tail");
    do_reset();

    // Round-robin fairness with credits replenished every cycle.
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] er;
      er = 4'b0001 << (k % 4);
      step(4'b1111, f(1, 1, 30'(16*k)), f(1, 1, 30'(16*k+1)), f(1, 1, 30'(16*k+2)),
           f(1, 1, 30'(16*k+3)), er, 1, "rr grant");
      check("rr out_valid", {31'b0, out_valid}, 1);
    end

    // Credit exhaustion on a 6-flit packet from requester 1.
    step(4'b0010, 0, f(1, 0, 30'h300), 0, 0, 4'b0010, 0, "exh f0");
    step(4'b0010, 0, f(0, 0, 30'h301), 0, 0, 4'b0010, 0, "exh f1");
    step(4'b0010, 0, f(0, 0, 30'h302), 0, 0, 4'b0010, 0, "exh f2");
    step(4'b0010, 0, f(0, 0, 30'h303), 0, 0, 4'b0010, 0, "exh f3");
    step(4'b0010, 0, f(0, 0, 30'h304), 0, 0, 4'b0000, 0, "exh stall");
    check("exh stall out_valid", {31'b0, out_valid}, 0);
    step(4'b0010, 0, f(0, 0, 30'h304), 0, 0, 4'b0000, 1, "exh credit cycle");
    check("exh credit out_valid", {31'b0, out_valid}, 0);
    step(4'b0010, 0, f(0, 0, 30'h304), 0, 0, 4'b0010, 0, "exh f4");
    step(4'b0010, 0, f(0, 1, 30'h305), 0, 0, 4'b0000, 0, "exh stall2");
    step(4'b0010, 0, f(0, 1, 30'h305), 0, 0, 4'b0000, 1, "exh credit2");
    step(4'b0010, 0, f(0, 1, 30'h305), 0, 0, 4'b0010, 0, "exh f5");
    do_reset();

    // Simultaneous transfer/credit and overflow detection.
    step(4'b0001, f(1, 1, 30'h400), 0, 0, 0, 4'b0001, 0, "sim a");
    step(4'b0010, 0, f(1, 1, 30'h401), 0, 0, 4'b0010, 1, "sim both");
    check("no err after both", {31'b0, credit_err}, 0);
    idle(1, "refill");
    check("no err at refill", {31'b0, credit_err}, 0);
    idle(1, "overflow");
    check("err on overflow", {31'b0, credit_err}, 1);
    idle(0, "overflow hold");
    check("err sticky", {31'b0, credit_err}, 1);
    step(4'b1000, 0, 0, 0, f(1, 1, 30'h402), 4'b1000, 0, "sim after err");
    check("err sticky 2", {31'b0, credit_err}, 1);

    // Reset in the middle of a packet from requester 2.
    step(4'b0100, 0, 0, f(1, 0, 30'h500), 0, 4'b0100, 0, "abort head");
    check("abort head out_valid", {31'b0, out_valid}, 1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    in_valid = '0;
    #1;
    check("async out_valid", {31'b0, out_valid}, 0);
    check("async out_data", out_data, 0);
    check("async credit_err", {31'b0, credit_err}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    expect_drained("drain after abort");
    idle(0, "post reset idle a");
    idle(0, "post reset idle b");
    step(4'b1000, 0, 0, 0, f(1, 0, 30'h600), 4'b1000, 0, "req3 head");
    step(4'b1000, 0, 0, 0, f(0, 0, 30'h601), 4'b1000, 0, "req3 b1");
    step(4'b1000, 0, 0, 0, f(0, 0, 30'h602), 4'b1000, 0, "req3 b2");
    step(4'b1000, 0, 0, 0, f(0, 0, 30'h603), 4'b1000, 0, "req3 b3");
    step(4'b1000, 0, 0, 0, f(0, 1, 30'h604), 4'b0000, 0, "req3 no credit");
    idle(0, "final idle");
    @(negedge clk);
    #1;
    expect_drained("final drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
